mc_ctrl_fsm: RTL

- Multicycle sequencing controller for the MIPS-subset datapath. It decodes the latched instruction's opcode and funct fields.
- It steps through the FETCH/DECODE/EXEC/MEM/WB phases and drives every datapath control strobe: PC, IR, RF and DM write enables, and the mux selects.
- Adds variable-latency memory handshakes, an illegal-opcode trap, and retired-instruction and cycle counters for the bench.

---
 rtl/mc_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS-subset sequencing controller with memory handshakes and counters
module mc_ctrl_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             mem_write,
  output logic [1:0]       mem2reg,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_ctrl_op,
  output logic             illegal_instr,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_ILLEGAL   = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] F_JR     = 6'b001000;

  state_t state;
  state_t next_state;
  logic   retire;

  function automatic logic is_load(input logic [5:0] o);
    case (o)
      6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] o);
    case (o)
      6'b101011, 6'b101000, 6'b101001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [5:0] o);
    case (o)
      6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift_imm(input logic [5:0] f);
    return (f == 6'b000000) || (f == 6'b000010) || (f == 6'b000011);
  endfunction

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      6'b001000, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
      6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // State register; reset parks the sequencer in FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // Next-state decode; jr is dispatched straight from DECODE so it retires in 3 cycles
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (imem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (op == OP_RTYPE)                next_state = (funct == F_JR) ? S_JR : S_R_EXEC;
        else if (is_load(op) || is_store(op)) next_state = S_MEM_ADDR;
        else if (is_branch(op))            next_state = S_BRANCH;
        else if (op == OP_J)               next_state = S_JUMP;
        else if (op == OP_JAL)             next_state = S_JAL;
        else if (op[5:3] == 3'b001)        next_state = S_I_EXEC;
        else                               next_state = S_ILLEGAL;
      end
      S_R_EXEC: begin
        if (funct == F_JR)       next_state = S_JR;
        else if (funct_ok(funct)) next_state = S_R_WB;
        else                      next_state = S_ILLEGAL;
      end
      S_R_WB:      next_state = S_FETCH;
      S_I_EXEC:    next_state = S_I_WB;
      S_I_WB:      next_state = S_FETCH;
      S_MEM_ADDR:  next_state = is_load(op) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (dmem_ready) next_state = S_MEM_WB;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: if (dmem_ready) next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      S_JAL:       next_state = S_FETCH;
      S_JR:        next_state = S_FETCH;
      S_ILLEGAL:   next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_FETCH;
    endcase
  end

  // Moore output decode; everything is forced low while reset is asserted
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    mem2reg       = 2'd0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    alu_a_sel     = 2'd0;
    alu_b_sel     = 2'd0;
    alu_ctrl_op   = 2'd0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        alu_b_sel = 2'd1;
        ir_write  = imem_ready;
        pc_write  = imem_ready;
      end
      S_DECODE:    alu_b_sel = 2'd3;
      S_R_EXEC: begin
        alu_a_sel   = is_shift_imm(funct) ? 2'd2 : 2'd1;
        alu_ctrl_op = 2'd2;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
      end
      S_I_EXEC: begin
        alu_a_sel   = 2'd1;
        alu_b_sel   = 2'd2;
        alu_ctrl_op = 2'd3;
      end
      S_I_WB:      reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_a_sel = 2'd1;
        alu_b_sel = 2'd2;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem2reg   = 2'd1;
      end
      S_MEM_WRITE: mem_write = 1'b1;
      S_BRANCH: begin
        alu_a_sel     = 2'd1;
        alu_ctrl_op   = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      // The RF captures the current PC, which FETCH already advanced to PC+4
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        reg_write = 1'b1;
        reg_dst   = 2'd2;
        mem2reg   = 2'd2;
      end
      S_JR: begin
        alu_a_sel   = 2'd1;
        alu_ctrl_op = 2'd2;
        pc_write    = 1'b1;
      end
      S_ILLEGAL:   illegal_instr = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'd0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      mem2reg       = 2'd0;
      reg_dst       = 2'd0;
      reg_write     = 1'b0;
      alu_a_sel     = 2'd0;
      alu_b_sel     = 2'd0;
      alu_ctrl_op   = 2'd0;
      illegal_instr = 1'b0;
    end
  end

  assign state_dbg = state;
  assign retire    = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_ILLEGAL);

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule
